// File: rtl/vote_arbiter.sv
// rtl/vote_arbiter.sv - single-ballot vote arbiter with round-robin tie break and saturating tallies
module vote_arbiter #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        ballot_arm,
  input  logic [NUM_CAND-1:0]         valid_vote,
  input  logic [$clog2(NUM_CAND)-1:0] result_sel,
  output logic                        armed,
  output logic                        vote_ack,
  output logic [$clog2(NUM_CAND)-1:0] vote_cand,
  output logic [CNT_W-1:0]            result_count,
  output logic [CNT_W+2:0]            total_votes,
  output logic                        overflow
);

  localparam int SEL_W  = $clog2(NUM_CAND);
  localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] RECORD  = 2'd2;
  localparam logic [1:0] LOCKOUT = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [LOCK_W-1:0] LOCK_START = LOCK_W'(LOCKOUT_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CAND];
  logic [CNT_W-1:0]  cnt_d [NUM_CAND];
  logic [CNT_W+2:0]  total_q, total_d;
  logic              overflow_q, overflow_d;
  logic              vote_ack_q, vote_ack_d;
  logic [SEL_W-1:0]  vote_cand_q, vote_cand_d;
  logic [CNT_W-1:0]  result_count_q, result_count_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic              rr_found;
  logic [SEL_W-1:0]  rr_pick;
  logic [SEL_W-1:0]  rr_idx;

  // Round-robin pick: first set request at or after the slot following the last winner
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      rr_idx = SEL_W'((int'(last_grant_q) + 1 + i) % NUM_CAND);
      if (!rr_found && valid_vote[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Ballot FSM, tally update on RECORD, lockout countdown
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    overflow_d   = overflow_q;
    vote_ack_d   = 1'b0;
    vote_cand_d  = vote_cand_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (ballot_arm && !mode) state_d = ARMED;
      end
      ARMED: begin
        if (mode) begin
          state_d = IDLE;
        end else if (rr_found) begin
          grant_d = rr_pick;
          state_d = RECORD;
        end
      end
      RECORD: begin
        vote_ack_d   = 1'b1;
        vote_cand_d  = grant_q;
        last_grant_d = grant_q;
        if (cnt_q[grant_q] == CNT_MAX) begin
          // Saturated tally: the vote is acknowledged but lost, and flagged
          overflow_d = 1'b1;
        end else begin
          cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
          total_d        = total_q + 1'b1;
        end
        lock_cnt_d = LOCK_START;
        state_d    = LOCKOUT;
      end
      LOCKOUT: begin
        if (lock_cnt_q == '0) state_d = IDLE;
        else                  lock_cnt_d = lock_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered result display, zero outside result mode or for an out-of-range index
  always_comb begin
    result_count_d = '0;
    if (mode && (int'(result_sel) < NUM_CAND)) result_count_d = cnt_q[result_sel];
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= SEL_W'(NUM_CAND - 1);
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_q        <= '0;
      overflow_q     <= 1'b0;
      vote_ack_q     <= 1'b0;
      vote_cand_q    <= '0;
      result_count_q <= '0;
      lock_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      total_q        <= total_d;
      overflow_q     <= overflow_d;
      vote_ack_q     <= vote_ack_d;
      vote_cand_q    <= vote_cand_d;
      result_count_q <= result_count_d;
      lock_cnt_q     <= lock_cnt_d;
    end
  end

  assign armed        = (state_q == ARMED);
  assign vote_ack     = vote_ack_q;
  assign vote_cand    = vote_cand_q;
  assign result_count = result_count_q;
  assign total_votes  = total_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/vote_arbiter.md
VOTE_ARBITER -- requirements
Module: vote_arbiter

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4, number of candidates (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-candidate vote counter.
REQ-003 SHALL have parameter LOCKOUT_CYC, default 16, idle cycles enforced after each recorded vote (>=1).
REQ-004 SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mode, input, 1, 0 = voting, 1 = result display.
REQ-007 SHALL have port ballot_arm, input, 1, officer pulse enabling exactly one vote.
REQ-008 SHALL have port valid_vote, input, NUM_CAND, per-candidate one-cycle pulses from the button debouncers.
REQ-009 SHALL have port result_sel, input, clog2(NUM_CAND), candidate index to display.
REQ-010 SHALL have port armed, output, 1, high while a ballot is open.
REQ-011 SHALL have port vote_ack, output, 1, one-cycle pulse when a vote is recorded.
REQ-012 SHALL have port vote_cand, output, clog2(NUM_CAND), index of the recorded candidate, valid with vote_ack.
REQ-013 SHALL have port result_count, output, CNT_W, count of candidate result_sel in result mode.
REQ-014 SHALL have port total_votes, output, CNT_W+3, sum of all recorded votes.
REQ-015 SHALL have port overflow, output, 1, sticky flag: a vote was lost to counter saturation.

Function
REQ-016 SHALL implement FSM IDLE, ARMED, RECORD, LOCKOUT; reset state IDLE.
REQ-017 IDLE -> ARMED SHALL occur when ballot_arm=1 and mode=0; ballot_arm in any other state or with mode=1 is ignored (no queuing).
REQ-018 armed SHALL be 1 exactly while state is ARMED.
REQ-019 In ARMED with mode=0 and valid_vote!=0, SHALL grant one candidate and go to RECORD next cycle; other simultaneous bits discarded.
REQ-020 Simultaneous votes SHALL be resolved round-robin: search starts at index (last_grant+1) mod NUM_CAND; last_grant resets to NUM_CAND-1 (first search starts at 0).
REQ-021 In ARMED, mode=1 SHALL return to IDLE (ballot cancelled, no vote recorded).
REQ-022 In RECORD (one cycle) SHALL increment the granted counter and total_votes, assert vote_ack=1 with vote_cand=grant, update last_grant, go to LOCKOUT.
REQ-023 Latency: valid_vote sampled at edge N -> vote_ack high during cycle N+1..N+2 (registered, exactly one cycle).
REQ-024 Counter at 2^CNT_W-1 SHALL saturate: no increment, total_votes unchanged, overflow set; vote_ack still pulses.
REQ-025 overflow SHALL stay 1 until reset.
REQ-026 LOCKOUT SHALL last exactly LOCKOUT_CYC cycles, ignoring valid_vote and ballot_arm, then go to IDLE.
REQ-027 RECORD and LOCKOUT SHALL complete regardless of mode changes.
REQ-028 valid_vote in IDLE or LOCKOUT SHALL have no effect.
REQ-029 result_count SHALL be registered: count[result_sel] one cycle after sampling when mode=1, else 0; result_sel >= NUM_CAND yields 0.
REQ-030 total_votes SHALL be registered and never wrap (width sufficient for NUM_CAND<=8 saturated counters).

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE, all counters 0, total_votes 0, last_grant NUM_CAND-1, armed 0, vote_ack 0, vote_cand 0, result_count 0, overflow 0.
REQ-032 Reset mid-RECORD or LOCKOUT SHALL discard the in-flight vote; deassertion SHALL return to IDLE with counts 0.

Verification
REQ-033 Arm, valid_vote=4'b0100 -> vote_ack one cycle, vote_cand=2, count[2]=1, total_votes=1, armed drops.
REQ-034 Arm, valid_vote=4'b1111 three times (after each lockout) -> vote_cand 0, 1, 2 in order.
REQ-035 valid_vote=4'b0001 while IDLE and during lockout; ballot_arm during lockout -> no vote_ack, counts unchanged, state returns to IDLE.
REQ-036 CNT_W=2: four votes for candidate 1 -> count[1]=3, vote_ack on all four, overflow=1 after fourth, total_votes=3.
REQ-037 Arm then mode=1 -> IDLE, no vote; mode=1, result_sel=2 after REQ-033 -> result_count=1 one cycle later.
REQ-038 Assert reset during LOCKOUT -> all outputs 0 immediately; next ballot records normally.
